s5378_cone_bist: RTL and testbench

- Sequential self-test driver for the extracted combinational s5378 cones: generates pseudo-random input vectors for a single-output cone and compacts the cone's response into a signature.
- It is the other end of the cone interface. The cone consumes a 20-bit gate-input vector and returns one output bit (e.g. n884). This block produces the vector and consumes that bit.
- It sits beside one cone instance in the BIST wrapper and reports pass/fail against a golden signature.

---
 rtl/s5378_bist_pkg.sv | 36 +++
 rtl/s5378_misr16.sv | 47 ++++
 rtl/s5378_cone_bist.sv | 131 +++++++++++++
 tb/tb_s5378_cone_bist.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s5378_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : s5378_bist_pkg
// Purpose  : Shared types and constants for the s5378 cone BIST driver:
//            FSM state encoding, LFSR20 taps, MISR16 polynomial, default seed
//            and the serial signature update function.
// Revision : 1.0  initial release
// ============================================================================
package s5378_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEED  = 2'd1,
    S_APPLY = 2'd2,
    S_CAPT  = 2'd3
  } bist_state_e;

  // Pattern generator: x^20 + x^17 + 1, maximal length, shift left
  localparam int unsigned c_LFSR_W      = 20;
  localparam int unsigned c_LFSR_TAP_HI = 19;
  localparam int unsigned c_LFSR_TAP_LO = 16;
  localparam logic [19:0] c_DEFAULT_SEED = 20'h00001;

  // Signature compactor: x^16 + x^15 + x^13 + x^4 + 1
  localparam int unsigned c_MISR_W    = 16;
  localparam logic [15:0] c_MISR_POLY = 16'hA011;

  // One serial MISR step: feedback is the outgoing MSB xor the response bit
  function automatic logic [15:0] misr16_step(input logic [15:0] sig_in, input logic din);
    logic fb;
    fb = sig_in[15] ^ din;
    return {sig_in[14:0], 1'b0} ^ (fb ? c_MISR_POLY : 16'h0000);
  endfunction

endpackage : s5378_bist_pkg
`default_nettype wire

// File: rtl/s5378_misr16.sv
`default_nettype none
// ============================================================================
// Module   : s5378_misr16
// Purpose  : 16-bit serial signature register with synchronous clear and
//            capture enable; also exposes the next signature so the caller
//            can compare against a golden value on the final capture.
// Revision : 1.0  initial release
// ============================================================================
module s5378_misr16
  import s5378_bist_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic                din_i,
  output logic [c_MISR_W-1:0] sig_o,
  output logic [c_MISR_W-1:0] sig_next_o
);

  logic [c_MISR_W-1:0] sig_q;
  logic [c_MISR_W-1:0] sig_d;

  // Next-signature selection: clear wins over capture
  always_comb begin
    sig_next_o = misr16_step(sig_q, din_i);
    sig_d      = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = sig_next_o;
    end
  end

  // Signature register, cleared asynchronously by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule : s5378_misr16
`default_nettype wire

// File: rtl/s5378_cone_bist.sv
`default_nettype none
// ============================================================================
// Module   : s5378_cone_bist
// Purpose  : Self-test driver for one extracted s5378 cone. Generates LFSR
//            patterns (registered, glitch-free), lets the cone settle for a
//            cycle, captures its output into a MISR and reports pass/fail
//            against a golden signature. Run length is 1 + 2*N_PAT cycles.
// Revision : 1.0  initial release
// ============================================================================
module s5378_cone_bist
  import s5378_bist_pkg::*;
#(
  parameter int unsigned      N_IN  = c_LFSR_W,
  parameter int unsigned      N_PAT = 1024,
  parameter int unsigned      SIG_W = c_MISR_W,
  parameter logic [N_IN-1:0]  SEED  = c_DEFAULT_SEED
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             start,
  input  logic             cone_out,
  input  logic [SIG_W-1:0] golden_sig,
  output logic [N_IN-1:0]  pat_vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig
);

  localparam int unsigned      CNT_W      = $clog2(N_PAT) + 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(N_PAT - 1);
  // An all-zero seed would lock the LFSR, so it is replaced by 1
  localparam logic [N_IN-1:0]  c_SEED_EFF = (SEED == '0) ? N_IN'(1) : SEED;

  bist_state_e      state_q, state_d;
  logic [N_IN-1:0]  lfsr_q,  lfsr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             pass_q,  pass_d;

  logic             misr_clr;
  logic             misr_en;
  logic [SIG_W-1:0] sig_cur;
  logic [SIG_W-1:0] sig_next;

  // Next-state and datapath control; every target holds unless a state moves it
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEED;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      S_SEED: begin
        lfsr_d   = c_SEED_EFF;
        cnt_d    = '0;
        misr_clr = 1'b1;
        state_d  = S_APPLY;
      end
      S_APPLY: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        misr_en = 1'b1;
        lfsr_d  = {lfsr_q[N_IN-2:0], lfsr_q[c_LFSR_TAP_HI] ^ lfsr_q[c_LFSR_TAP_LO]};
        if (cnt_q == c_CNT_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Compare the post-capture signature so the last pattern counts
          pass_d  = (sig_next == golden_sig);
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_APPLY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and control registers; reset aborts any run without flagging done
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= S_IDLE;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  s5378_misr16 u_misr (
    .clk_i      (CK),
    .rst_ni     (RN),
    .clr_i      (misr_clr),
    .en_i       (misr_en),
    .din_i      (cone_out),
    .sig_o      (sig_cur),
    .sig_next_o (sig_next)
  );

  assign pat_vec = lfsr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign sig     = sig_cur;

endmodule : s5378_cone_bist
`default_nettype wire

// File: tb/tb_s5378_cone_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_s5378_cone_bist
// Purpose  : Self-checking bench for s5378_cone_bist with an emulated cone,
//            a trajectory-based reference model and randomized runs.
// Revision : 1.0  initial release
// ============================================================================
module tb_s5378_cone_bist;

  localparam int N_PAT = 16;
  localparam int RUN   = 1 + 2 * N_PAT;

  logic        CK = 1'b0;
  logic        RN = 1'b1;
  logic        start, start0;
  logic        cone_out, cone_out0;
  logic [15:0] golden, golden0;
  logic [19:0] pat_vec, pat_vec0;
  logic        busy, done, pass, busy0, done0, pass0;
  logic [15:0] sig, sig0;

  logic [1:0]  mode;   // 0: stuck-at-0, 1: stuck-at-1, 2: logic cone
  logic [19:0] mask;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  always #5 CK = ~CK;

  // ---------------------------------------------------------------- helpers
  function automatic logic [19:0] lfsr_step(input logic [19:0] v);
    return 20'((v * 2) | (((v >> 19) ^ (v >> 16)) & 20'h1));
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
    int t;
    t = (int'(s) * 2) % 65536;
    if (((int'(s) >> 15) & 1) != int'(b)) t = t ^ 'hA011;
    return 16'(t);
  endfunction

  function automatic logic cone_fn(input logic [19:0] v, input logic [1:0] md, input logic [19:0] mk);
    if (md == 2'd0) return 1'b0;
    if (md == 2'd1) return 1'b1;
    return (^(v & mk)) ^ (v[2] & v[7]);
  endfunction

  function automatic logic [15:0] expected_sig(input logic [1:0] md, input logic [19:0] mk);
    logic [19:0] v;
    logic [15:0] s;
    v = 20'h1;
    s = 16'h0;
    for (int i = 0; i < N_PAT; i++) begin
      s = misr_step(s, cone_fn(v, md, mk));
      v = lfsr_step(v);
    end
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- DUTs
  assign cone_out  = cone_fn(pat_vec,  mode, mask);
  assign cone_out0 = cone_fn(pat_vec0, mode, mask);

  s5378_cone_bist #(.N_PAT(N_PAT)) dut (
    .CK(CK), .RN(RN), .start(start), .cone_out(cone_out), .golden_sig(golden),
    .pat_vec(pat_vec), .busy(busy), .done(done), .pass(pass), .sig(sig)
  );

  s5378_cone_bist #(.N_PAT(1), .SEED(20'h00000)) dut0 (
    .CK(CK), .RN(RN), .start(start0), .cone_out(cone_out0), .golden_sig(golden0),
    .pat_vec(pat_vec0), .busy(busy0), .done(done0), .pass(pass0), .sig(sig0)
  );

  // ---------------------------------------------------------------- model
  // On acceptance the whole run is precomputed: pattern list, running
  // signatures, then outputs are looked up by edges elapsed since accept.
  logic [19:0] m_pats [0:N_PAT];
  logic [15:0] m_sigs [0:N_PAT];
  logic [19:0] m_pat;
  logic [15:0] m_sig;
  logic        m_busy, m_done, m_pass;
  int          m_t;

  always @(posedge CK or negedge RN) begin
    if (!RN) begin
      m_pat = '0; m_sig = '0; m_busy = 0; m_done = 0; m_pass = 0; m_t = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_done = 0; m_pass = 0; m_t = 0;
        m_pats[0] = 20'h1;
        m_sigs[0] = 16'h0;
        for (int i = 0; i < N_PAT; i++) begin
          m_pats[i+1] = lfsr_step(m_pats[i]);
          m_sigs[i+1] = misr_step(m_sigs[i], cone_fn(m_pats[i], mode, mask));
        end
      end
    end else begin
      m_t++;
      m_pat = m_pats[(m_t - 1) / 2];
      m_sig = m_sigs[(m_t - 1) / 2];
      if (m_t == RUN) begin
        m_busy = 0;
        m_done = 1;
        m_pass = (m_sigs[N_PAT] == golden);
      end
    end
  end

  // Cycle-by-cycle comparison, away from the active edge
  always @(negedge CK) begin
    if (cmp_en) begin
      chk("pat_vec", 32'(pat_vec), 32'(m_pat));
      chk("sig",     32'(sig),     32'(m_sig));
      chk("busy",    32'(busy),    32'(m_busy));
      chk("done",    32'(done),    32'(m_done));
      chk("pass",    32'(pass),    32'(m_pass));
    end
  end

  task automatic check_reset_zero(input string nm);
    chk({nm, "_pat"},  32'(pat_vec), 0);
    chk({nm, "_sig"},  32'(sig),     0);
    chk({nm, "_busy"}, 32'(busy),    0);
    chk({nm, "_done"}, 32'(done),    0);
    chk({nm, "_pass"}, 32'(pass),    0);
  endtask

  // Pulse start for one cycle; returns at the first negedge after acceptance
  task automatic kick();
    @(negedge CK) start = 1'b1;
    @(negedge CK) start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge CK);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [19:0] v;
    logic [15:0] s;
    int n, p, t, hold, rst_t, extra;
    bit zero_seen, do_rst, rerun;

    start = 0; start0 = 0; mode = 0; mask = 0; golden = 0; golden0 = 0;
    #1 RN = 1'b0;
    repeat (3) @(negedge CK);
    check_reset_zero("reset");
    chk("reset_busy0", 32'(busy0), 0);
    cmp_en = 1'b1;
    RN = 1'b1;

    // Pin the model helpers against hand-derived values
    v = 20'h1;
    for (int i = 0; i < 4; i++) begin
      chk("model_lfsr", 32'(v), 32'(1) << i);
      v = lfsr_step(v);
    end
    s = misr_step(16'h0, 1'b1); chk("model_misr1", 32'(s), 32'hA011);
    s = misr_step(s, 1'b1);     chk("model_misr2", 32'(s), 32'h4022);
    s = misr_step(s, 1'b1);     chk("model_misr3", 32'(s), 32'h2055);
    s = misr_step(s, 1'b1);     chk("model_misr4", 32'(s), 32'hE0BB);

    // LFSR period and zero-avoidance over the full sequence
    v = 20'h1; p = 0; zero_seen = 0;
    do begin
      v = lfsr_step(v);
      p++;
      if (v == 20'h0) zero_seen = 1;
    end while (v != 20'h1 && p < 1100000);
    chk("lfsr_period", 32'(p), 32'd1048575);
    chk("lfsr_nonzero", 32'(zero_seen), 0);

    // Stuck-at-0 response, golden 0
    mode = 0; golden = 16'h0000;
    kick();
    wait_idle(n);
    chk("sa0_busy_cycles", 32'(n), 32'(RUN));
    chk("sa0_done", 32'(done), 1);
    chk("sa0_pass", 32'(pass), 1);
    chk("sa0_sig", 32'(sig), 0);
    chk("sa0_final_pat", 32'(pat_vec), 32'h10000);

    // Stuck-at-1 response, intermediate signatures
    mode = 1; golden = 16'h0000;
    kick();
    repeat (5) @(negedge CK);
    chk("sa1_sig_after2", 32'(sig), 32'h4022);
    repeat (4) @(negedge CK);
    chk("sa1_sig_after4", 32'(sig), 32'hE0BB);
    wait_idle(n);
    chk("sa1_pass_wrong_golden", 32'(pass), 0);

    // Logic cone with start pulses while busy
    mode = 2; mask = 20'h5A3C7;
    golden = expected_sig(mode, mask);
    kick();
    n = 0;
    while (busy && n < 200) begin
      start = (n == 2 || n == 4);
      n++;
      @(negedge CK);
    end
    start = 0;
    chk("ignore_start_cycles", 32'(n), 32'(RUN));
    chk("cone_pass", 32'(pass), 1);

    // Reset mid-run at pattern 10, then a clean rerun
    mode = 0; golden = 16'h0;
    kick();
    repeat (21) @(negedge CK);
    chk("pat10", 32'(pat_vec), 32'h00400);
    #2 RN = 1'b0;
    #1 check_reset_zero("midrun_rst");
    @(negedge CK) RN = 1'b1;
    kick();
    @(negedge CK); chk("rerun_pat0", 32'(pat_vec), 32'h00001);
    repeat (2) @(negedge CK); chk("rerun_pat1", 32'(pat_vec), 32'h00002);
    wait_idle(n);
    chk("rerun_done", 32'(done), 1);

    // Zero seed build, single pattern
    mode = 1; golden0 = 16'hA011;
    @(negedge CK) start0 = 1'b1;
    @(negedge CK) start0 = 1'b0;
    chk("seed0_busy", 32'(busy0), 1);
    @(negedge CK); chk("seed0_first_pat", 32'(pat_vec0), 32'h00001);
    repeat (2) @(negedge CK);
    chk("seed0_done", 32'(done0), 1);
    chk("seed0_busy_end", 32'(busy0), 0);
    chk("seed0_pass", 32'(pass0), 1);
    chk("seed0_sig", 32'(sig0), 32'hA011);
    chk("seed0_next_pat", 32'(pat_vec0), 32'h00002);

    // Randomized runs
    for (int it = 0; it < 40; it++) begin
      mode   = 2'($urandom_range(0, 2));
      mask   = 20'($urandom);
      golden = ($urandom_range(0, 1) == 1) ? expected_sig(mode, mask) : 16'($urandom);
      hold   = $urandom_range(1, 3);
      do_rst = ($urandom_range(0, 5) == 0);
      rst_t  = $urandom_range(1, 2 * N_PAT);
      extra  = $urandom_range(0, 2 * N_PAT);
      rerun  = ($urandom_range(0, 3) == 0);

      @(negedge CK) start = 1'b1;
      repeat (hold) @(negedge CK);
      start = 1'b0;
      t = hold - 1;
      while (busy && t < 300) begin
        if (do_rst && t == rst_t) begin
          #2 RN = 1'b0;
          #1 check_reset_zero("rand_rst");
          @(negedge CK) RN = 1'b1;
          break;
        end
        start = (t == extra);
        t++;
        @(negedge CK);
      end
      start = 1'b0;
      if (!do_rst) begin
        chk("rand_run_end", {30'd0, busy, done}, 32'b01);
        if (rerun) begin
          start = 1'b1;
          @(negedge CK) start = 1'b0;
          chk("rerun_clears_done", 32'(done), 0);
          chk("rerun_busy", 32'(busy), 1);
          wait_idle(n);
          chk("rerun_end", {30'd0, busy, done}, 32'b01);
        end
      end
      @(negedge CK);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_s5378_cone_bist
`default_nettype wire
